// File: rtl/rptr_empty_ctrl.sv
`default_nettype none
// ============================================================================
// rptr_empty_ctrl : async-FIFO read-side pointer, empty/almost-empty, level
// Revision 1.0
// ============================================================================
module rptr_empty_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AE_THRESH  = 2
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rinc,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  input  logic                  rclr_err,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH:0]   rlevel,
  output logic                  rvalid,
  output logic                  runderflow
);

  localparam logic [ADDR_WIDTH:0] C_AE_THRESH = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [ADDR_WIDTH:0] r_rbin;
  logic                w_rd_ok;
  logic                w_rd_blocked;
  logic [ADDR_WIDTH:0] w_rbinnext;
  logic [ADDR_WIDTH:0] w_rgraynext;
  logic [ADDR_WIDTH:0] w_wbin_s;
  logic [ADDR_WIDTH:0] w_level_next;

  assign w_rd_ok      = rinc & ~rempty;
  assign w_rd_blocked = rinc & rempty;
  assign w_rbinnext   = r_rbin + {{ADDR_WIDTH{1'b0}}, w_rd_ok};
  assign w_rgraynext  = (w_rbinnext >> 1) ^ w_rbinnext;

  // Gray to binary: each bit is the XOR of all Gray bits at or above it
  for (genvar i = 0; i <= ADDR_WIDTH; i++) begin : g_g2b
    assign w_wbin_s[i] = ^(rq2_wptr >> i);
  end

  assign w_level_next = w_wbin_s - w_rbinnext;
  assign raddr        = r_rbin[ADDR_WIDTH-1:0];

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_rbin        <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
      rvalid        <= 1'b0;
      runderflow    <= 1'b0;
    end else begin
      r_rbin        <= w_rbinnext;
      rptr          <= w_rgraynext;
      rempty        <= (w_rgraynext == rq2_wptr);
      rlevel        <= w_level_next;
      ralmost_empty <= (w_level_next <= C_AE_THRESH);
      rvalid        <= w_rd_ok;
      // a fresh underflow takes priority over a clear in the same cycle
      if (w_rd_blocked)
        runderflow <= 1'b1;
      else if (rclr_err)
        runderflow <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/rptr_empty_ctrl.md
RPTR_EMPTY_CTRL -- requirements
Module: rptr_empty_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: FIFO depth is 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits wide.
REQ-002 Parameter AE_THRESH, default 2: almost-empty threshold in entries, legal range 0..2**ADDR_WIDTH.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 rclk  input  1  read-domain clock; all state updates on its rising edge.
REQ-005 rrst  input  1  asynchronous active-high reset.
REQ-006 rinc  input  1  read request; accepted only when rempty=0.
REQ-007 rq2_wptr  input  ADDR_WIDTH+1  Gray-coded write pointer, already synchronized into rclk.
REQ-008 rclr_err  input  1  clears the sticky underflow flag.
REQ-009 raddr  output  ADDR_WIDTH  binary memory read address.
REQ-010 rptr  output  ADDR_WIDTH+1  Gray-coded read pointer, for synchronization into the write domain.
REQ-011 rempty  output  1  registered FIFO-empty flag.
REQ-012 ralmost_empty  output  1  registered flag, level <= AE_THRESH.
REQ-013 rlevel  output  ADDR_WIDTH+1  registered occupancy as seen from the read domain, 0..2**ADDR_WIDTH.
REQ-014 rvalid  output  1  read data valid, one cycle after an accepted read.
REQ-015 runderflow  output  1  sticky flag, read attempted while empty.

Function
REQ-016 Binary read counter rbin (ADDR_WIDTH+1 bits) holds the next read position.
- rbinnext = rbin + (rinc & ~rempty), modulo 2**(ADDR_WIDTH+1).
REQ-017 rgraynext = (rbinnext >> 1) XOR rbinnext; rbin<=rbinnext and rptr<=rgraynext on each rclk edge.
REQ-018 raddr = rbin[ADDR_WIDTH-1:0], combinational from the register with no extra latency.
REQ-019 rempty <= (rgraynext == rq2_wptr), so the flag reflects the read accepted in the same cycle.
REQ-020 Write pointer conversion: wbin_s = Gray-to-binary(rq2_wptr), combinational; bit i = XOR of rq2_wptr bits ADDR_WIDTH..i.
REQ-021 rlevel <= (wbin_s - rbinnext) modulo 2**(ADDR_WIDTH+1).
- rlevel==0 whenever rempty==1, in the same cycle.
- With legal inputs, rlevel never exceeds 2**ADDR_WIDTH.
REQ-022 ralmost_empty <= (level_next <= AE_THRESH), where level_next is the value loaded into rlevel.
REQ-023 rvalid <= rinc & ~rempty; no read is accepted and rvalid stays 0 when rempty=1.
REQ-024 A read on empty (rinc=1, rempty=1) is blocked.
- rbin and rptr are unchanged.
- runderflow <= 1 on the next edge.
REQ-025 runderflow clears on an edge where rclr_err=1 and no new underflow occurs.
- If set and clear happen in the same cycle, set wins.
REQ-026 Pointer wrap: binary 2**(ADDR_WIDTH+1)-1 rolls over to 0.
- The Gray value then changes in exactly one bit (for example 10000 -> 00000 at ADDR_WIDTH=4).
REQ-027 rq2_wptr may change on any cycle, including a cycle with an accepted read; flags use its current value.
REQ-028 The block has no combinational path from rq2_wptr or rinc to any output.

Reset
REQ-029 While rrst=1, regardless of rclk, all outputs take their reset values immediately:
- rbin=0, rptr=0, raddr=0
- rempty=1, ralmost_empty=1, rlevel=0
- rvalid=0, runderflow=0
REQ-030 On rrst deassertion, normal operation starts at the first rclk edge after deassertion; reset in mid-operation discards all state.

Verification
REQ-031 Reset check: rrst=1 -> rempty=1, ralmost_empty=1, rlevel=0, rptr=00000, rvalid=0, runderflow=0.
REQ-032 Fill and drain (ADDR_WIDTH=4, AE_THRESH=2), rq2_wptr=00111 (binary 5), rinc=0:
- Next edge: rempty=0, rlevel=5, ralmost_empty=0.
- After 3 reads: rlevel=2, ralmost_empty=1, rvalid high one cycle after each read.
- After 5 reads: rempty=1, raddr=5, rptr=00111.
REQ-033 Underflow: with rempty=1, hold rinc=1 -> rptr unchanged, rvalid=0, runderflow=1.
- rclr_err=1 with rinc=1 still set -> runderflow stays 1.
- rclr_err=1 with rinc=0 -> runderflow=0.
REQ-034 Full level: rptr=00000 and rq2_wptr=11000 (binary 16) -> rlevel=16, rempty=0, ralmost_empty=0.
REQ-035 Wrap: advance writes and reads through 33 entries -> rptr goes binary 31 (Gray 10000) -> 0 (Gray 00000), and raddr, rlevel and rempty stay consistent throughout.
REQ-036 Mid-operation reset: assert rrst between rclk edges with rlevel=7 -> all outputs reach their reset values before the next rclk edge.
